id_hazard_stall_unit: RTL and testbench

- Hazard detection and stall sequencer for the ID stage; sits directly upstream of the ID control-signal bubble mux and drives its i_Risk input.
- Detects load-use and branch-in-ID operand hazards and sequences 1- or 2-cycle stalls via a small FSM.
- Gates PC and IF/ID writes, honours the debug step enable, latches HALT into a sticky halted state, and keeps a saturating stall counter for the debug unit.

---
 rtl/id_hazard_stall_unit.sv | 128 ++++++++++++
 tb/tb_id_hazard_stall_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_stall_unit.sv
// ID-stage hazard detector and stall sequencer: load-use and branch-operand
// hazards, 1/2-cycle stall FSM, sticky HALT and a saturating stall counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; o_Risk follows the combinational hazard check
// STALL   | second bubble of a branch-after-load; hazard inputs ignored
// HALTED  | HALT retired; fetch frozen until reset
module id_hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_Enable,
  input  logic [REG_ADDR_W-1:0]  i_IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0]  i_IF_ID_Rt,
  input  logic                   i_ID_UsesRt,
  input  logic                   i_ID_Branch,
  input  logic                   i_HALT,
  input  logic                   i_ID_EX_MemRead,
  input  logic                   i_ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0]  i_ID_EX_WriteReg,
  input  logic                   i_EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0]  i_EX_MEM_WriteReg,
  output logic                   o_Risk,
  output logic                   o_PCWrite,
  output logic                   o_IF_ID_Write,
  output logic                   o_Halted,
  output logic [STALL_CNT_W-1:0] o_StallCount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [1:0]             rem, rem_nxt;
  logic [STALL_CNT_W-1:0] cnt, cnt_nxt;
  logic                   match_ex, match_mem;
  logic [1:0]             need;
  logic                   risk, pc_write, halted;

  // Register 0 is hard-wired, so a zero destination never creates a hazard.
  always_comb begin
    match_ex  = (i_ID_EX_WriteReg != '0) &&
                ((i_IF_ID_Rs == i_ID_EX_WriteReg) ||
                 (i_ID_UsesRt && (i_IF_ID_Rt == i_ID_EX_WriteReg)));
    match_mem = (i_EX_MEM_WriteReg != '0) &&
                ((i_IF_ID_Rs == i_EX_MEM_WriteReg) ||
                 (i_ID_UsesRt && (i_IF_ID_Rt == i_EX_MEM_WriteReg)));
  end

  always_comb begin
    need = 2'd0;
    if (i_ID_Branch && i_ID_EX_MemRead && match_ex)
      need = 2'd2;
    else if ((i_ID_EX_MemRead && match_ex) ||
             (i_ID_Branch && i_ID_EX_RegWrite && match_ex) ||
             (i_ID_Branch && i_EX_MEM_MemRead && match_mem))
      need = 2'd1;
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    risk      = 1'b0;
    pc_write  = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_RUN: begin
        risk     = (need != 2'd0);
        pc_write = i_Enable & ~risk;
        if (i_Enable) begin
          if (need == 2'd2) begin
            state_nxt = ST_STALL;
            rem_nxt   = 2'd1;
          end else if ((need == 2'd0) && i_HALT) begin
            state_nxt = ST_HALTED;
          end
        end
      end
      ST_STALL: begin
        risk = 1'b1;
        if (i_Enable) begin
          rem_nxt = rem - 2'd1;
          if (rem == 2'd1)
            state_nxt = ST_RUN;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
        rem_nxt   = 2'd0;
      end
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (i_Enable && risk && (cnt != '1))
      cnt_nxt = cnt + STALL_CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= ST_RUN;
      rem   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are held low for the whole reset cycle, not just after the edge.
  assign o_Risk        = i_reset & risk;
  assign o_PCWrite     = i_reset & pc_write;
  assign o_IF_ID_Write = i_reset & pc_write;
  assign o_Halted      = i_reset & halted;
  assign o_StallCount  = i_reset ? cnt : '0;

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
// Scoreboard bench for id_hazard_stall_unit: each row drives one cycle of
// inputs and pushes the hand-derived outputs expected for that cycle.
module tb_id_hazard_stall_unit;

  typedef struct packed {
    logic        risk;
    logic        pcw;
    logic        ifw;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       rst, en;
    logic [4:0] rs, rt;
    logic       uses, br, halt, ex_mr, ex_rw;
    logic [4:0] ex_wr;
    logic       mem_mr;
    logic [4:0] mem_wr;
    exp_t       exp;
  } row_t;

  logic        clk = 1'b0;
  logic        reset, enable, uses_rt, br, halt, ex_mr, ex_rw, mem_mr;
  logic [4:0]  rs, rt, ex_wr, mem_wr;
  logic        risk, pcw, ifw, halted;
  logic [15:0] cnt;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  id_hazard_stall_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_Enable          (enable),
    .i_IF_ID_Rs        (rs),
    .i_IF_ID_Rt        (rt),
    .i_ID_UsesRt       (uses_rt),
    .i_ID_Branch       (br),
    .i_HALT            (halt),
    .i_ID_EX_MemRead   (ex_mr),
    .i_ID_EX_RegWrite  (ex_rw),
    .i_ID_EX_WriteReg  (ex_wr),
    .i_EX_MEM_MemRead  (mem_mr),
    .i_EX_MEM_WriteReg (mem_wr),
    .o_Risk            (risk),
    .o_PCWrite         (pcw),
    .o_IF_ID_Write     (ifw),
    .o_Halted          (halted),
    .o_StallCount      (cnt)
  );

  // Field order: rst en rs rt uses br halt ex_mr ex_rw ex_wr mem_mr mem_wr | risk pcw halted cnt
  function automatic row_t r(input logic rst_v, en_v, input logic [4:0] rs_v, rt_v,
                             input logic uses_v, br_v, halt_v, exmr_v, exrw_v,
                             input logic [4:0] exwr_v, input logic memmr_v,
                             input logic [4:0] memwr_v, input logic e_risk, e_pcw,
                             e_halted, input logic [15:0] e_cnt);
    row_t x;
    x.rst = rst_v; x.en = en_v; x.rs = rs_v; x.rt = rt_v; x.uses = uses_v;
    x.br = br_v; x.halt = halt_v; x.ex_mr = exmr_v; x.ex_rw = exrw_v;
    x.ex_wr = exwr_v; x.mem_mr = memmr_v; x.mem_wr = memwr_v;
    x.exp.risk = e_risk; x.exp.pcw = e_pcw; x.exp.ifw = e_pcw;
    x.exp.halted = e_halted; x.exp.cnt = e_cnt;
    return x;
  endfunction

  task automatic apply(input row_t x);
    reset = x.rst; enable = x.en; rs = x.rs; rt = x.rt; uses_rt = x.uses;
    br = x.br; halt = x.halt; ex_mr = x.ex_mr; ex_rw = x.ex_rw;
    ex_wr = x.ex_wr; mem_mr = x.mem_mr; mem_wr = x.mem_wr;
    sb.push_back(x.exp);
  endtask

  task automatic test_reset;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(0,1, 0,0,0,0,0,0,0,0,0,0, 0,0,0,16'd0));
    rows.push_back(r(0,1, 5,0,0,0,0,1,0,5,0,0, 0,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd0));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL reset[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_load_use;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 5,0,0,0,0,1,0,5,0,0, 1,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd1));
    rows.push_back(r(1,1, 0,7,1,0,0,1,0,7,0,0, 1,0,0,16'd1));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd2));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL load_use[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 6,0,0,0,0,1,0,6,0,0, 1,0,0,16'd2));
    rows.push_back(r(1,1, 0,6,1,0,0,1,1,6,0,0, 1,0,0,16'd3));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd4));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_branch;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 0,8,1,1,0,1,1,8,0,0, 1,0,0,16'd4));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 1,0,0,16'd5));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd6));
    rows.push_back(r(1,1, 9,0,0,1,0,0,1,9,0,0, 1,0,0,16'd6));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd7));
    rows.push_back(r(1,1,10,0,0,1,0,0,0,0,1,10, 1,0,0,16'd7));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd8));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL branch[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reg_zero;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 0,0,0,0,0,1,0,0,0,0, 0,1,0,16'd8));
    rows.push_back(r(1,1, 0,3,0,0,0,1,0,3,0,0, 0,1,0,16'd8));
    rows.push_back(r(1,1, 0,0,0,1,0,1,1,0,1,0, 0,1,0,16'd8));
    rows.push_back(r(1,1, 4,0,0,0,0,0,1,4,0,0, 0,1,0,16'd8));
    rows.push_back(r(1,1, 4,0,0,0,0,0,0,0,1,4, 0,1,0,16'd8));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL reg_zero[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_step_enable;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 8,0,0,1,0,1,0,8,0,0, 1,0,0,16'd8));
    rows.push_back(r(1,0, 0,0,0,0,0,0,0,0,0,0, 1,0,0,16'd9));
    rows.push_back(r(1,0, 0,0,0,0,0,0,0,0,0,0, 1,0,0,16'd9));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 1,0,0,16'd9));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd10));
    rows.push_back(r(1,0, 5,0,0,0,0,1,0,5,0,0, 1,0,0,16'd10));
    rows.push_back(r(1,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,16'd10));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd10));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL step_enable[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_halt_hazard;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 5,0,0,0,1,1,0,5,0,0, 1,0,0,16'd10));
    rows.push_back(r(1,1, 0,0,0,0,1,0,0,0,0,0, 0,1,0,16'd11));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,0,1,16'd11));
    rows.push_back(r(1,1, 5,0,0,0,0,1,0,5,0,0, 0,0,1,16'd11));
    rows.push_back(r(1,0, 0,0,0,0,0,0,0,0,0,0, 0,0,1,16'd11));
    rows.push_back(r(1,1, 0,0,0,0,1,0,0,0,0,0, 0,0,1,16'd11));
    rows.push_back(r(0,1, 0,0,0,0,0,0,0,0,0,0, 0,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd0));
    // HALT during a two-cycle branch stall is only honoured once back in RUN.
    rows.push_back(r(1,1, 8,0,0,1,1,1,0,8,0,0, 1,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,1,0,0,0,0,0, 1,0,0,16'd1));
    rows.push_back(r(1,1, 0,0,0,0,1,0,0,0,0,0, 0,1,0,16'd2));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,0,1,16'd2));
    rows.push_back(r(0,1, 0,0,0,0,0,0,0,0,0,0, 0,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd0));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL halt_hazard[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    row_t rows[$];
    exp_t e, got;
    rows.push_back(r(1,1, 8,0,0,1,0,1,0,8,0,0, 1,0,0,16'd0));
    rows.push_back(r(0,1, 0,0,0,0,0,0,0,0,0,0, 0,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd0));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL reset_mid_stall[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_saturation;
    row_t rows[$];
    row_t hold;
    exp_t e, got;
    hold = r(1,1, 5,0,0,0,0,1,0,5,0,0, 1,0,0,16'd0);
    reset = hold.rst; enable = hold.en; rs = hold.rs; rt = hold.rt;
    uses_rt = hold.uses; br = hold.br; halt = hold.halt; ex_mr = hold.ex_mr;
    ex_rw = hold.ex_rw; ex_wr = hold.ex_wr; mem_mr = hold.mem_mr; mem_wr = hold.mem_wr;
    repeat (65540) @(negedge clk);
    rows.push_back(r(1,1, 5,0,0,0,0,1,0,5,0,0, 1,0,0,16'hFFFF));
    rows.push_back(r(1,1, 5,0,0,0,0,1,0,5,0,0, 1,0,0,16'hFFFF));
    rows.push_back(r(0,1, 5,0,0,0,0,1,0,5,0,0, 0,0,0,16'd0));
    rows.push_back(r(1,1, 0,0,0,0,0,0,0,0,0,0, 0,1,0,16'd0));
    foreach (rows[i]) begin
      @(negedge clk); apply(rows[i]); #2;
      e = sb.pop_front(); got = {risk, pcw, ifw, halted, cnt}; tests++;
      if (got !== e) begin
        failed++; $display("FAIL saturation[%0d] got=%h expected=%h", i, got, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; rs = '0; rt = '0; uses_rt = 1'b0; br = 1'b0;
    halt = 1'b0; ex_mr = 1'b0; ex_rw = 1'b0; ex_wr = '0; mem_mr = 1'b0; mem_wr = '0;
    test_reset;
    test_load_use;
    test_back_to_back;
    test_branch;
    test_reg_zero;
    test_step_enable;
    test_halt_hazard;
    test_reset_mid_stall;
    test_saturation;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_500_000;
    failed++;
    $display("FAIL watchdog time=%0t limit=1500000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
